// File: rtl/mac_tx_pkg.sv
// Shared types and constants for the MAC TX frame arbiter.
//   state_t     : arbiter FSM states
//   tx_beat_t   : one byte plus framing flags as forwarded to the MAC
//   NREQ_MAX    : largest supported requester count
//   ABORTS_W    : width of the watchdog abort counter
package mac_tx_pkg;

  localparam int unsigned NREQ_MAX = 4;
  localparam int unsigned ABORTS_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    XFER  = 3'd2,
    GAP   = 3'd3,
    ABORT = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;
  } tx_beat_t;

endpackage

// File: rtl/mac_tx_arbiter_rr_pick.sv
// Combinational one-hot requester selector.
//   i_req    : request vector
//   i_ptr    : index to start scanning from (upward, modulo N)
//   i_strict : ignore i_ptr and scan from index 0 (fixed priority)
//   o_grant  : one-hot winner, zero when no request
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_strict,
  output logic [N-1:0]  o_grant
);

  int unsigned w_base;
  int unsigned w_idx;
  logic        w_found;

  // First set request at or after the base index, wrapping at N.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 32'd0;
    w_base  = i_strict ? 32'd0 : 32'(i_ptr);
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = w_base + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && i_req[PW'(w_idx)]) begin
        o_grant[PW'(w_idx)] = 1'b1;
        w_found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-granular arbiter sharing one MAC TX byte interface between NREQ
// sources, with a minimum inter-frame gap and a stall watchdog.
// Build option: define STRICT_PRIORITY_EN for fixed lowest-index priority
// instead of round-robin.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   req                   : per-source frame request
//   src_data/sop/eop/err/wren : per-source byte stream (byte i at [8i+7:8i])
//   src_rdy               : per-source ready (combinational)
//   grant                 : one-hot current owner
//   tx_clk                : forwarded clk
//   tx_data/sop/eop/err/wren : registered byte stream to the MAC
//   tx_rdy, tx_a_full     : MAC flow control
//   aborts                : saturating watchdog abort count
module mac_tx_arbiter
  import mac_tx_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned STALL_MAX  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   src_data,
  input  logic [NREQ-1:0]     src_sop,
  input  logic [NREQ-1:0]     src_eop,
  input  logic [NREQ-1:0]     src_err,
  input  logic [NREQ-1:0]     src_wren,
  output logic [NREQ-1:0]     src_rdy,
  output logic [NREQ-1:0]     grant,
  output logic                tx_clk,
  output logic [7:0]          tx_data,
  output logic                tx_sop,
  output logic                tx_eop,
  output logic                tx_err,
  output logic                tx_wren,
  input  logic                tx_rdy,
  input  logic                tx_a_full,
  output logic [ABORTS_W-1:0] aborts
);

  localparam int unsigned PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned STALL_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;

`ifdef STRICT_PRIORITY_EN
  localparam logic STRICT = 1'b1;
`else
  localparam logic STRICT = 1'b0;
`endif

  state_t               r_state, w_state_d;
  logic [NREQ-1:0]      r_grant, w_grant_d;
  logic [PTR_W-1:0]     r_owner, w_owner_d;
  logic [PTR_W-1:0]     r_ptr, w_ptr_d;
  logic [GAP_W-1:0]     r_gap, w_gap_d;
  logic [STALL_W-1:0]   r_stall, w_stall_d;
  tx_beat_t             r_beat, w_beat_d;
  logic                 r_wren, w_wren_d;
  logic [ABORTS_W-1:0]  r_aborts, w_aborts_d;

  logic [NREQ-1:0]      w_pick;
  logic [PTR_W-1:0]     w_pick_idx;
  logic                 w_rdy_ok;
  logic                 w_acc;
  logic                 w_owner_req;
  tx_beat_t             w_in_beat;
  logic [PTR_W-1:0]     w_ptr_adv;
  logic [STALL_W-1:0]   w_stall_inc;
  logic                 w_stall_hit;
  logic [ABORTS_W-1:0]  w_aborts_inc;

  rr_pick #(.N(NREQ), .PW(PTR_W)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .i_strict (STRICT),
    .o_grant  (w_pick)
  );

  // Binary index of the picked requester.
  always_comb begin
    w_pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
  end

  // Owner's byte, selected by the registered one-hot grant.
  always_comb begin
    w_in_beat = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        w_in_beat.data = src_data[8*i +: 8];
        w_in_beat.sop  = src_sop[i];
        w_in_beat.eop  = src_eop[i];
        w_in_beat.err  = src_err[i];
      end
    end
  end

  assign w_rdy_ok     = tx_rdy & ~tx_a_full;
  assign src_rdy      = r_grant & {NREQ{w_rdy_ok}};
  assign w_acc        = |(src_wren & src_rdy);
  assign w_owner_req  = |(req & r_grant);
  assign w_ptr_adv    = (32'(r_owner) >= NREQ - 1) ? '0 : r_owner + PTR_W'(1);
  assign w_stall_inc  = r_stall + STALL_W'(1);
  assign w_stall_hit  = (STALL_MAX != 0) && (32'(w_stall_inc) == STALL_MAX);
  assign w_aborts_inc = (&r_aborts) ? r_aborts : r_aborts + ABORTS_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    w_state_d  = r_state;
    w_grant_d  = r_grant;
    w_owner_d  = r_owner;
    w_ptr_d    = r_ptr;
    w_gap_d    = r_gap;
    w_stall_d  = r_stall;
    w_beat_d   = '0;
    w_wren_d   = 1'b0;
    w_aborts_d = r_aborts;

    unique case (r_state)
      IDLE: begin
        w_stall_d = '0;
        if (|req) begin
          w_grant_d = w_pick;
          w_owner_d = w_pick_idx;
          w_state_d = GRANT;
        end
      end

      GRANT, XFER: begin
        if (w_acc) begin
          w_wren_d  = 1'b1;
          w_beat_d  = w_in_beat;
          w_stall_d = '0;
          // A frame must open with sop; flag it so the MAC drops the frame.
          if (r_state == GRANT && !w_in_beat.sop) w_beat_d.err = 1'b1;
          if (w_in_beat.eop) begin
            w_state_d = GAP;
            w_grant_d = '0;
            w_gap_d   = GAP_W'(GAP_CYCLES);
            w_ptr_d   = w_ptr_adv;
          end else begin
            w_state_d = XFER;
          end
        end else if (r_state == GRANT && !w_owner_req) begin
          // Source withdrew before sending anything: release quietly.
          w_state_d = IDLE;
          w_grant_d = '0;
        end else if (w_rdy_ok && STALL_MAX != 0) begin
          w_stall_d = w_stall_inc;
          if (w_stall_hit) begin
            // Close the frame with an errored eop beat presented in ABORT.
            w_state_d     = ABORT;
            w_grant_d     = '0;
            w_ptr_d       = w_ptr_adv;
            w_stall_d     = '0;
            w_aborts_d    = w_aborts_inc;
            w_wren_d      = 1'b1;
            w_beat_d.eop  = 1'b1;
            w_beat_d.err  = 1'b1;
          end
        end
      end

      ABORT: begin
        w_state_d = GAP;
        w_gap_d   = GAP_W'(GAP_CYCLES);
      end

      GAP: begin
        if (r_gap <= GAP_W'(1)) begin
          w_state_d = IDLE;
          w_gap_d   = '0;
        end else begin
          w_gap_d = r_gap - GAP_W'(1);
        end
      end

      default: w_state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_gap    <= '0;
      r_stall  <= '0;
      r_beat   <= '0;
      r_wren   <= 1'b0;
      r_aborts <= '0;
    end else begin
      r_state  <= w_state_d;
      r_grant  <= w_grant_d;
      r_owner  <= w_owner_d;
      r_ptr    <= w_ptr_d;
      r_gap    <= w_gap_d;
      r_stall  <= w_stall_d;
      r_beat   <= w_beat_d;
      r_wren   <= w_wren_d;
      r_aborts <= w_aborts_d;
    end
  end

  assign grant   = r_grant;
  assign tx_clk  = clk;
  assign tx_data = r_beat.data;
  assign tx_sop  = r_beat.sop;
  assign tx_eop  = r_beat.eop;
  assign tx_err  = r_beat.err;
  assign tx_wren = r_wren;
  assign aborts  = r_aborts;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter (NREQ=2, GAP_CYCLES=16, STALL_MAX=8).
module tb_mac_tx_arbiter;

`ifdef STRICT_PRIORITY_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] src_data;
  logic [1:0]  src_sop, src_eop, src_err, src_wren;
  logic [1:0]  src_rdy, grant;
  logic        tx_clk;
  logic [7:0]  tx_data;
  logic        tx_sop, tx_eop, tx_err, tx_wren;
  logic        tx_rdy, tx_a_full;
  logic [15:0] aborts;

  int n_vec  = 0;
  int n_miss = 0;

  mac_tx_arbiter #(.NREQ(2), .GAP_CYCLES(16), .STALL_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_data(src_data),
    .src_sop(src_sop), .src_eop(src_eop), .src_err(src_err), .src_wren(src_wren),
    .src_rdy(src_rdy), .grant(grant), .tx_clk(tx_clk), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_err(tx_err), .tx_wren(tx_wren),
    .tx_rdy(tx_rdy), .tx_a_full(tx_a_full), .aborts(aborts)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_src();
    src_data = '0; src_sop = '0; src_eop = '0; src_err = '0; src_wren = '0;
  endtask

  task automatic drive_byte(input int s, input logic [7:0] d, input logic sop, input logic eop);
    idle_src();
    src_data[8*s +: 8] = d;
    src_sop[s]  = sop;
    src_eop[s]  = eop;
    src_wren[s] = 1'b1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (grant == 2'b00 && n < 60) begin
      step();
      n++;
    end
  endtask

  // Expected winner: lowest index in strict mode, else scan from pointer.
  function automatic logic [1:0] pick(input logic [1:0] r, input int p);
    if (STRICT || p == 0) return r[0] ? 2'b01 : (r[1] ? 2'b10 : 2'b00);
    return r[1] ? 2'b10 : (r[0] ? 2'b01 : 2'b00);
  endfunction

  // Sends len bytes from source s; optionally holds tx_a_full for hold_len
  // cycles while byte hold_at is offered. Each byte is checked on tx one cycle later.
  task automatic send(input int s, input int len, input int hold_at, input int hold_len,
                      input logic [7:0] base, input logic close);
    for (int k = 0; k < len; k++) begin
      drive_byte(s, 8'(base + k), k == 0, close && (k == len - 1));
      if (k == hold_at) begin
        tx_a_full = 1'b1;
        for (int h = 0; h < hold_len; h++) begin
          step();
          check("hold_quiet", 32'({src_rdy, tx_wren}), 32'd0);
        end
        tx_a_full = 1'b0;
      end
      step();
      check("tx_byte", 32'({tx_wren, tx_sop, tx_eop, tx_err, tx_data}),
            32'({1'b1, k == 0, close && (k == len - 1), 1'b0, 8'(base + k)}));
    end
    idle_src();
  endtask

  initial begin
    int n;
    int s;
    int exp_ptr;
    logic [1:0] g;

    rst_n = 1'b1; req = '0; idle_src(); tx_rdy = 1'b1; tx_a_full = 1'b0;
    exp_ptr = 0;
    #1 rst_n = 1'b0;
    step();
    check("reset_outs", 32'({grant, src_rdy, tx_wren, tx_sop, tx_eop, tx_err, tx_data, aborts}), 32'd0);
    check("tx_clk", 32'(tx_clk), 32'(clk));

    // Single source, 60-byte frame, then gap before the next grant.
    step();
    rst_n = 1'b1;
    req = 2'b01;
    wait_grant(n);
    check("req_to_grant", n, 32'd1);
    check("single_grant", 32'(grant), 32'(2'b01));
    check("single_rdy", 32'(src_rdy), 32'(2'b01));
    send(0, 60, -1, 0, 8'h10, 1'b1);
    exp_ptr = 1;
    check("grant_clr_eop", 32'(grant), 32'd0);
    wait_grant(n);
    check("gap_len", n, 32'd17);
    check("regrant", 32'(grant), 32'(pick(2'b01, exp_ptr)));
    // Withdraw before any byte: back to IDLE, nothing sent, pointer kept.
    req = 2'b00;
    step();
    check("withdraw", 32'({grant, tx_wren}), 32'd0);

    // Contention: both sources request, three frames each.
    req = 2'b11;
    for (int f = 0; f < 6; f++) begin
      wait_grant(n);
      g = pick(2'b11, exp_ptr);
      check("rr_grant", 32'(grant), 32'(g));
      check("rr_rdy", 32'(src_rdy), 32'(g));
      s = g[1] ? 1 : 0;
      send(s, 3, -1, 0, 8'(8'h40 + 16 * f), 1'b1);
      exp_ptr = (s + 1) % 2;
    end

    // Backpressure: 20 almost-full cycles mid-frame, no abort.
    req = 2'b10;
    wait_grant(n);
    check("bp_grant", 32'(grant), 32'(pick(2'b10, exp_ptr)));
    send(1, 20, 10, 20, 8'hA0, 1'b1);
    exp_ptr = 0;
    req = 2'b00;
    check("bp_no_abort", 32'(aborts), 32'd0);

    // Watchdog: source 0 stops after 11 bytes; abort after 8 stalled cycles.
    req = 2'b01;
    wait_grant(n);
    check("wd_grant", 32'(grant), 32'(pick(2'b01, exp_ptr)));
    send(0, 11, -1, 0, 8'hC0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      step();
      check("wd_stall", 32'({tx_wren, grant}), 32'({1'b0, 2'b01}));
    end
    step();
    check("wd_abort_beat", 32'({tx_wren, tx_sop, tx_eop, tx_err, tx_data}),
          32'({1'b1, 1'b0, 1'b1, 1'b1, 8'h00}));
    check("wd_aborts", 32'(aborts), 32'd1);
    check("wd_grant_clr", 32'(grant), 32'd0);
    exp_ptr = 1;
    req = 2'b11;
    wait_grant(n);
    check("wd_ptr_adv", 32'(grant), 32'(pick(2'b11, exp_ptr)));
    req = 2'b00;
    step();
    check("wd_withdraw", 32'({grant, tx_wren}), 32'd0);

    // Reset in the middle of a frame from source 0.
    req = 2'b01;
    wait_grant(n);
    check("rst_grant", 32'(grant), 32'(pick(2'b01, exp_ptr)));
    send(0, 30, -1, 0, 8'h20, 1'b0);
    drive_byte(0, 8'h3E, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 32'({grant, src_rdy, tx_wren, tx_sop, tx_eop, tx_err, tx_data, aborts}), 32'd0);
    exp_ptr = 0;
    step();
    idle_src();
    rst_n = 1'b1;
    req = 2'b10;
    wait_grant(n);
    check("post_rst_grant", 32'(grant), 32'(pick(2'b10, exp_ptr)));
    send(1, 4, -1, 0, 8'h70, 1'b1);
    req = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
Frame-granular round-robin arbiter that shares the single MAC TX byte interface between NREQ frame sources, such as the IQ packetizer and a control/ARP reply generator. It grants one source per frame, passes that source's bytes to the MAC through one register stage, and enforces a minimum idle gap between frames. A stall watchdog terminates a frame with an error if the granted source stops writing.

Parameters:
NREQ, 2, number of requesters (2..4)
GAP_CYCLES, 16, minimum idle cycles between the EOP of one frame and the next grant
STALL_MAX, 255, maximum consecutive cycles without a write while a frame is open before abort (0 disables the watchdog)

Ports:
clk  in  1  system clock; also forwarded as tx_clk
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-source frame request; held high until the source's EOP byte is accepted
src_data  in  8*NREQ  per-source byte; source i occupies [8i+7:8i]
src_sop  in  NREQ  per-source start of frame
src_eop  in  NREQ  per-source end of frame
src_err  in  NREQ  per-source frame error
src_wren  in  NREQ  per-source byte write
src_rdy  out  NREQ  per-source ready
grant  out  NREQ  one-hot current owner; all zero when no source owns the MAC
tx_clk  out  1  equals clk
tx_data  out  8  byte to MAC
tx_sop  out  1  start of frame to MAC
tx_eop  out  1  end of frame to MAC
tx_err  out  1  frame error to MAC
tx_wren  out  1  byte write to MAC
tx_rdy  in  1  MAC ready
tx_a_full  in  1  MAC FIFO almost full
aborts  out  16  saturating count of watchdog aborts

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, round-robin pointer at 0, gap and stall counters 0. Deasserting reset mid-frame does not resume the frame; the MAC's own framing discards it.
- States: IDLE -> GRANT -> XFER -> GAP -> IDLE, plus ABORT.
- IDLE: if any req bit is high, pick the first requester at or after the pointer, scanning upward modulo NREQ. Latch it into grant and go to GRANT. Grant is registered, so there is one cycle from req to grant.
- src_rdy[i] = grant[i] & tx_rdy & ~tx_a_full, combinational. Every other source sees rdy=0.
- A byte is accepted when src_wren[i] & src_rdy[i]. On the next cycle tx_data/sop/eop/err are the registered copy and tx_wren=1. Otherwise tx_wren=0 and tx_sop, tx_eop, tx_err are 0. Latency is one cycle.
- GRANT -> XFER on the first accepted byte. A first byte without sop is forwarded with tx_err=1.
- XFER: an accepted byte with eop goes to GAP, clears grant, loads the gap counter with GAP_CYCLES and sets pointer = owner+1 (mod NREQ). A sop while in XFER is forwarded unchanged.
- Stall counter: cleared on each accepted byte. It increments in GRANT/XFER only while tx_rdy & ~tx_a_full and no write occurs. When it reaches STALL_MAX (nonzero), go to ABORT.
- ABORT: for one cycle drive tx_wren=1, tx_eop=1, tx_err=1, tx_data=0. Increment aborts (saturating at 16'hFFFF), clear grant, advance the pointer, go to GAP. The aborted source must drop req. A req still high after ABORT re-enters arbitration normally.
- GAP: decrement once per cycle and go to IDLE at 0. GAP_CYCLES=0 returns to IDLE on the next cycle. Requests arriving during GAP wait.
- req dropped while in GRANT before any byte: return to IDLE with no output and no pointer change.
- Simultaneous requests: round-robin order only. One source can never hold the MAC for two consecutive frames while another source is requesting.

Optional Feature:
STRICT_PRIORITY_EN
- Defined: IDLE always grants the lowest-index requesting source; the pointer is ignored and is still maintained.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package mac_tx_pkg holds the state enum (IDLE, GRANT, XFER, GAP, ABORT), the NREQ maximum constant, and the width constant for the aborts counter.
- One sub-module, rr_pick: combinational one-hot selector (req, pointer, strict flag) -> grant vector, reused by other arbiters.

Test Plan:
- Single source: req[0]=1 with a 60-byte frame, tx_rdy=1 -> grant=01 one cycle later; 60 bytes appear on tx_data in order, one cycle after each write; sop on byte 0, eop on byte 59; then 16 idle cycles before any new grant.
- Contention: req=11 held, each source sends 3 frames -> grants alternate 01,10,01,10,01,10; no interleaved bytes.
- Backpressure: tx_a_full=1 for 20 cycles mid-frame -> src_rdy=0, no tx_wren, stall counter does not advance, no abort; the frame completes intact.
- Watchdog: STALL_MAX=8, source stops writing after byte 10 -> after 8 stalled cycles one cycle of tx_wren=tx_eop=tx_err=1, aborts=1, pointer advances.
- Reset mid-frame: rst_n=0 at byte 30 -> all outputs 0 immediately, before the next clock edge; after release, a fresh frame from source 1 is granted first if pointer=0 and only req[1] is high.
- STRICT_PRIORITY_EN defined, req=11 continuously -> source 0 granted every frame.
